// File: rtl/main_memory_responder_if.sv
// Cache-to-main-memory request/response bundle.
// The cache drives the master side and the memory responder drives the slave side.
interface main_memory_responder_if;
    logic        mem_req;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_ack;
    logic        mem_busy;
    logic        mem_err;

    modport master (
        output mem_req, write_en, address, mem_data_in,
        input  mem_data_out, mem_ack, mem_busy, mem_err
    );

    modport slave (
        input  mem_req, write_en, address, mem_data_in,
        output mem_data_out, mem_ack, mem_busy, mem_err
    );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed main memory with fixed read/write latency and a one-cycle ack pulse.
// Optional upper-address range checking is enabled with `define MEM_RANGE_CHECK_EN.
module main_memory_responder #(
    parameter int MEM_WORDS     = 16384,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    main_memory_responder_if.slave  bus
);
    localparam int IDX_W    = $clog2(MEM_WORDS);
    localparam int ADDR_MSB = 2 + IDX_W - 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             rerr_q, rerr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             go_resp;
    logic             commit;
    logic             req_rerr;

    logic [31:0] mem [MEM_WORDS];

`ifdef MEM_RANGE_CHECK_EN
    logic unused_bits;
    assign req_rerr    = |bus.address[31:ADDR_MSB+1];
    assign bus.mem_err = (state_q == RESP) && rerr_q;
    assign unused_bits = ^bus.address[1:0];
`else
    logic unused_bits;
    assign req_rerr    = 1'b0;
    assign bus.mem_err = 1'b0;
    assign unused_bits = ^{bus.address[31:ADDR_MSB+1], bus.address[1:0], rerr_q};
`endif

    // The _d request fields equal the live inputs on the accepting edge and the
    // latched copy afterwards, so commit/read logic uses them in either case.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rerr_d  = rerr_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    idx_d   = bus.address[ADDR_MSB:2];
                    we_d    = bus.write_en;
                    wdata_d = bus.mem_data_in;
                    rerr_d  = req_rerr;
                    cnt_d   = bus.write_en ? 4'(WRITE_LATENCY - 1) : 4'(READ_LATENCY - 1);
                    if (cnt_d == '0) begin
                        go_resp = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = bus.write_en ? WRITE_WAIT : READ_WAIT;
                    end
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    go_resp = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        commit  = go_resp && we_d && !rerr_d;
        rdata_d = rdata_q;
        if (go_resp && !we_d) begin
            rdata_d = rerr_d ? '0 : mem[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; a reset edge simply blocks the pending commit.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign bus.mem_ack      = (state_q == RESP);
    assign bus.mem_busy     = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);
    assign bus.mem_data_out = rdata_q;
endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: driver queues expected acks, a negedge monitor checks them.
// Range-check expectations follow `define MEM_RANGE_CHECK_EN when the RTL is built with it.
module tb_main_memory_responder;
    localparam int RL = 4;
    localparam int WL = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    main_memory_responder_if bus();

    main_memory_responder #(
        .MEM_WORDS    (16384),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        logic        err;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.mem_ack === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=1 at cycle %0d expected no ack", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_latency"}, cyc - e.acc_cyc + 1, e.is_wr ? WL : RL);
                check({e.name, "_err"}, {31'b0, bus.mem_err}, {31'b0, e.err});
                check({e.name, "_busy_in_resp"}, {31'b0, bus.mem_busy}, 32'd0);
                if (e.is_wr) begin
                    check({e.name, "_data_held"}, bus.mem_data_out, last_rd);
                end else begin
                    check({e.name, "_rdata"}, bus.mem_data_out, e.data);
                    last_rd = e.data;
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input logic expect_ack, input string name);
        bus.mem_req     = 1'b1;
        bus.write_en    = wr;
        bus.address     = addr;
        bus.mem_data_in = wdata;
        @(negedge clk);
        if (expect_ack) sb.push_back('{wr, exp_data, exp_err, cyc, name});
        bus.mem_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"},  {31'b0, bus.mem_ack},  32'd0);
        check({name, "_busy"}, {31'b0, bus.mem_busy}, 32'd0);
        check({name, "_err"},  {31'b0, bus.mem_err},  32'd0);
        check({name, "_dout"}, bus.mem_data_out,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        range_err;
        logic [31:0] word0_after;
`ifdef MEM_RANGE_CHECK_EN
        range_err   = 1'b1;
        word0_after = 32'hA5A5A5A5;
`else
        range_err   = 1'b0;
        word0_after = 32'h00000001;
`endif
        bus.mem_req     = 1'b0;
        bus.write_en    = 1'b0;
        bus.address     = '0;
        bus.mem_data_in = '0;
        reset           = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_init");
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read-back with exact latencies
        issue(1'b1, 32'h0000_0100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, "wr_100");
        wait_done(20);
        issue(1'b0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "rd_100");
        wait_done(20);

        // Byte-offset bits ignored; byte 0 sits in [31:24]
        issue(1'b1, 32'h0000_0104, 32'h11223344, 32'h0, 1'b0, 1'b1, "wr_104");
        wait_done(20);
        issue(1'b0, 32'h0000_0105, 32'h0, 32'h11223344, 1'b0, 1'b1, "rd_105");
        wait_done(20);
        check("byte0", {24'b0, bus.mem_data_out[31:24]}, 32'h11);

        // Request during READ_WAIT is dropped; changing inputs after acceptance has no effect
        issue(1'b0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "rd_busy");
        check("busy_in_wait", {31'b0, bus.mem_busy}, 32'd1);
        bus.mem_req     = 1'b1;
        bus.write_en    = 1'b1;
        bus.address     = 32'h0000_0104;
        bus.mem_data_in = 32'hFFFFFFFF;
        @(negedge clk);
        bus.mem_req = 1'b0;
        wait_done(20);
        issue(1'b0, 32'h0000_0104, 32'h0, 32'h11223344, 1'b0, 1'b1, "rd_104_after_ignore");
        wait_done(20);

        // Reset in cycle 3 of a write aborts it
        issue(1'b1, 32'h0000_0200, 32'h12345678, 32'h0, 1'b0, 1'b1, "wr_200_prior");
        wait_done(20);
        issue(1'b1, 32'h0000_0200, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, "wr_200_abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        last_rd = '0;
        check_reset_outputs("reset_mid_write");
        repeat (8) @(negedge clk);
        issue(1'b0, 32'h0000_0200, 32'h0, 32'h12345678, 1'b0, 1'b1, "rd_200_after_abort");
        wait_done(20);

        // Reset wins over a request on the same edge
        reset        = 1'b1;
        bus.mem_req  = 1'b1;
        bus.write_en = 1'b0;
        bus.address  = 32'h0000_0100;
        @(negedge clk);
        reset       = 1'b0;
        bus.mem_req = 1'b0;
        last_rd     = '0;
        check_reset_outputs("reset_vs_req");
        repeat (8) @(negedge clk);
        check("reset_vs_req_idle", {31'b0, bus.mem_busy}, 32'd0);

        // Upper address bits: range error or modulo wrap depending on build
        issue(1'b1, 32'h0000_0000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, "wr_word0");
        wait_done(20);
        issue(1'b1, 32'h0001_0000, 32'h00000001, 32'h0, range_err, 1'b1, "wr_10000");
        wait_done(20);
        issue(1'b0, 32'h0000_0000, 32'h0, word0_after, 1'b0, 1'b1, "rd_word0");
        wait_done(20);
        issue(1'b0, 32'h0001_0000, 32'h0, range_err ? 32'h0 : word0_after, range_err, 1'b1, "rd_10000");
        wait_done(20);

        // Back-to-back reads with mem_req held: one ack every RL+1 cycles
        bus.mem_req  = 1'b1;
        bus.write_en = 1'b0;
        bus.address  = 32'h0000_0104;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b0, 32'h11223344, 1'b0, cyc + k * (RL + 1), "b2b_rd"});
        end
        for (int i = 0; i < 3 * (RL + 1); i++) begin
            check("b2b_busy", {31'b0, bus.mem_busy}, {31'b0, ((i % (RL + 1)) <= RL - 2)});
            if (i == 3 * (RL + 1) - 1) bus.mem_req = 1'b0;
            @(negedge clk);
        end
        wait_done(20);
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter MEM_WORDS, 16384, number of 32-bit words in the array (64 KB).
REQ-002 Parameter READ_LATENCY, 4, cycles from request acceptance to read mem_ack; legal range 1..15.
REQ-003 Parameter WRITE_LATENCY, 5, cycles from request acceptance to write mem_ack; legal range 1..15.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port mem_req  input  1  request strobe from cache; sampled only while idle.
REQ-007 Port write_en  input  1  1 = write-back of a victim word, 0 = line fill read.
REQ-008 Port address  input  32  byte address from cache; bits [1:0] ignored.
REQ-009 Port mem_data_in  input  32  write data; [31:24] = byte 0 (lowest address), [7:0] = byte 3.
REQ-010 Port mem_data_out  output  32  read data, same byte order as mem_data_in.
REQ-011 Port mem_ack  output  1  one-cycle completion pulse for the accepted request.
REQ-012 Port mem_busy  output  1  high while a request is in flight; requests ignored.
REQ-013 Port mem_err  output  1  range-error flag, valid with mem_ack (see Configuration).

Function
REQ-014 FSM states: IDLE, READ_WAIT, WRITE_WAIT, RESP.
REQ-015 In IDLE with mem_req=1 at edge N: latch address, write_en, mem_data_in; enter READ_WAIT or WRITE_WAIT; mem_busy=1 from cycle N+1.
REQ-016 Latency counter loads LATENCY-1 at acceptance and decrements per cycle in the WAIT state; at 0, go to RESP.
REQ-017 RESP lasts exactly one cycle: mem_ack=1, mem_busy=0, then return to IDLE; mem_ack high in cycle N+LATENCY after acceptance.
REQ-018 Write commit: array[word index] updated with the latched data on the same edge that enters RESP; no earlier visibility.
REQ-019 Read: mem_data_out loaded from array[word index] on the edge entering RESP and held until the next read completes; writes leave it unchanged.
REQ-020 Word index = latched address[ADDR_MSB:2], where ADDR_MSB = 2 + clog2(MEM_WORDS) - 1.
REQ-021 mem_req while mem_busy=1 or during RESP is ignored and never queued; the cache must hold or re-assert mem_req.
REQ-022 mem_req in the IDLE cycle right after RESP is accepted normally, so back-to-back accesses take LATENCY+1 cycles each.
REQ-023 Changes on address, write_en or mem_data_in after acceptance have no effect on the in-flight request.

Reset
REQ-024 reset=1 at any edge forces IDLE, clears the counter, and drives mem_ack=0, mem_busy=0, mem_err=0, mem_data_out=32'h0.
REQ-025 Reset during WRITE_WAIT aborts the write: the array is unchanged. Array contents are never cleared by reset.
REQ-026 reset has priority over mem_req sampled at the same edge.

Configuration
REQ-027 Macro MEM_RANGE_CHECK_EN defined: address[31:ADDR_MSB+1] nonzero produces mem_err=1 together with mem_ack; writes are suppressed; reads return 32'h0.
REQ-028 MEM_RANGE_CHECK_EN undefined: upper address bits are ignored (modulo wrap), and mem_err is tied to 0.
REQ-029 Latency and handshake timing are identical with and without the macro.

Verification
REQ-030 Write 0x00000100 data 0xDEADBEEF, accepted cycle 0 -> mem_ack only at cycle 5; then read 0x100 -> mem_ack at cycle 4 after acceptance, mem_data_out=0xDEADBEEF.
REQ-031 Write 0x104 data 0x11223344, then read 0x105 -> 0x11223344 (bits [1:0] ignored); byte 0 = 0x11.
REQ-032 Read accepted, mem_req pulsed with write 0x104/0xFFFFFFFF during READ_WAIT -> second request ignored; later read 0x104 still returns 0x11223344.
REQ-033 Write 0x200 data 0xCAFEF00D, reset asserted in cycle 3 -> no mem_ack, outputs zero; read 0x200 returns the prior content.
REQ-034 Macro defined: write 0x00010000 data 0x1 (MEM_WORDS=16384) -> mem_ack with mem_err=1, word 0 unchanged; macro undefined: same write lands in word 0 and mem_err=0.
REQ-035 Back-to-back reads with mem_req held high -> mem_ack every 5 cycles (READ_LATENCY+1) and mem_busy low only in RESP and IDLE cycles.
